// File: rtl/if_id_stage_pkg.sv
// Shared constants for the pipeline front end: opcodes, bubble encoding, PC step.
// Also holds the source-register-use decode helpers.
package if_id_stage_pkg;

  localparam int unsigned OPCODE_BITWIDTH = 7;

  localparam logic [OPCODE_BITWIDTH-1:0] OP_LUI   = 7'b0110111;
  localparam logic [OPCODE_BITWIDTH-1:0] OP_AUIPC = 7'b0010111;
  localparam logic [OPCODE_BITWIDTH-1:0] OP_JAL   = 7'b1101111;
  localparam logic [OPCODE_BITWIDTH-1:0] OP_R     = 7'b0110011;
  localparam logic [OPCODE_BITWIDTH-1:0] OP_S     = 7'b0100011;
  localparam logic [OPCODE_BITWIDTH-1:0] OP_B     = 7'b1100011;
  localparam logic [OPCODE_BITWIDTH-1:0] OP_LOAD  = 7'b0000011;

  localparam logic [31:0] NOP_ENCODING = 32'h0000_0013;
  localparam logic [31:0] PC_STEP      = 32'd4;

  // U-type and JAL carry no rs1 field
  function automatic logic uses_rs1(input logic [OPCODE_BITWIDTH-1:0] op);
    return !((op == OP_LUI) || (op == OP_AUIPC) || (op == OP_JAL));
  endfunction

  function automatic logic uses_rs2(input logic [OPCODE_BITWIDTH-1:0] op);
    return (op == OP_R) || (op == OP_S) || (op == OP_B);
  endfunction

endpackage

// File: rtl/if_id_stage_hazard_unit.sv
// Load-use hazard detector: the load in EX writes a register the ID instruction reads.
module hazard_unit
  import if_id_stage_pkg::*;
#(
  parameter int unsigned WORD_BITWIDTH    = 32,
  parameter int unsigned REG_NUM_BITWIDTH = 5
) (
  input  logic [WORD_BITWIDTH-1:0]    id_inst_i,
  input  logic                        id_valid_i,
  input  logic                        ex_mem_read_i,
  input  logic [REG_NUM_BITWIDTH-1:0] ex_reg_to_write_i,
  output logic                        hazard_o
);

  logic [OPCODE_BITWIDTH-1:0]  opcode;
  logic [REG_NUM_BITWIDTH-1:0] rs1;
  logic [REG_NUM_BITWIDTH-1:0] rs2;
  logic                        rs1_match;
  logic                        rs2_match;
  logic                        unused_inst_bits;

  assign opcode = id_inst_i[6:0];
  assign rs1    = REG_NUM_BITWIDTH'(id_inst_i[19:15]);
  assign rs2    = REG_NUM_BITWIDTH'(id_inst_i[24:20]);

  assign rs1_match = uses_rs1(opcode) && (ex_reg_to_write_i == rs1);
  assign rs2_match = uses_rs2(opcode) && (ex_reg_to_write_i == rs2);

  // x0 is never a real dependency
  assign hazard_o = id_valid_i && ex_mem_read_i && (ex_reg_to_write_i != '0) &&
                    (rs1_match || rs2_match);

  assign unused_inst_bits = ^{id_inst_i[WORD_BITWIDTH-1:25], id_inst_i[14:7]};

endmodule

// File: rtl/if_id_stage.sv
// Pipeline front end: PC register, IF/ID register, load-use stall and redirect flush.
// doNOP is combinational so ID/EX can insert its bubble in the same cycle.
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter int unsigned           WORD_BITWIDTH    = 32,
  parameter int unsigned           REG_NUM_BITWIDTH = 5,
  parameter logic [WORD_BITWIDTH-1:0] RESET_PC      = 32'h0000_0000,
  parameter logic [WORD_BITWIDTH-1:0] NOP_INST      = NOP_ENCODING,
  parameter int unsigned           CNT_BITWIDTH     = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic [WORD_BITWIDTH-1:0]    imem_addr,
  input  logic [WORD_BITWIDTH-1:0]    imem_rdata,
  input  logic                        ex_memRead,
  input  logic [REG_NUM_BITWIDTH-1:0] ex_regToWrite,
  input  logic                        branch_taken,
  input  logic [WORD_BITWIDTH-1:0]    branch_target,
  output logic [WORD_BITWIDTH-1:0]    id_inst,
  output logic [WORD_BITWIDTH-1:0]    id_pc,
  output logic                        id_valid,
  output logic [REG_NUM_BITWIDTH-1:0] Rs1,
  output logic [REG_NUM_BITWIDTH-1:0] Rs2,
  output logic                        doNOP,
  output logic [CNT_BITWIDTH-1:0]     stall_cnt,
  output logic [CNT_BITWIDTH-1:0]     flush_cnt
);

  logic [WORD_BITWIDTH-1:0] pc_q, pc_d;
  logic [WORD_BITWIDTH-1:0] id_inst_q, id_inst_d;
  logic [WORD_BITWIDTH-1:0] id_pc_q, id_pc_d;
  logic                     id_valid_q, id_valid_d;
  logic [CNT_BITWIDTH-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_BITWIDTH-1:0]  flush_cnt_q, flush_cnt_d;
  logic                     hazard;
  logic                     unused_target_bits;

  hazard_unit #(
    .WORD_BITWIDTH   (WORD_BITWIDTH),
    .REG_NUM_BITWIDTH(REG_NUM_BITWIDTH)
  ) u_hazard_unit (
    .id_inst_i        (id_inst_q),
    .id_valid_i       (id_valid_q),
    .ex_mem_read_i    (ex_memRead),
    .ex_reg_to_write_i(ex_regToWrite),
    .hazard_o         (hazard)
  );

  // Redirect beats stall beats normal fetch
  always_comb begin
    pc_d        = pc_q;
    id_inst_d   = id_inst_q;
    id_pc_d     = id_pc_q;
    id_valid_d  = id_valid_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (branch_taken) begin
      pc_d       = {branch_target[WORD_BITWIDTH-1:2], 2'b00};
      id_inst_d  = NOP_INST;
      id_pc_d    = '0;
      id_valid_d = 1'b0;
      if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_BITWIDTH'(1);
    end else if (hazard) begin
      if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_BITWIDTH'(1);
    end else begin
      pc_d       = pc_q + WORD_BITWIDTH'(PC_STEP);
      id_inst_d  = imem_rdata;
      id_pc_d    = pc_q;
      id_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      id_inst_q   <= NOP_INST;
      id_pc_q     <= '0;
      id_valid_q  <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      pc_q        <= pc_d;
      id_inst_q   <= id_inst_d;
      id_pc_q     <= id_pc_d;
      id_valid_q  <= id_valid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign imem_addr = pc_q;
  assign id_inst   = id_inst_q;
  assign id_pc     = id_pc_q;
  assign id_valid  = id_valid_q;
  assign Rs1       = REG_NUM_BITWIDTH'(id_inst_q[19:15]);
  assign Rs2       = REG_NUM_BITWIDTH'(id_inst_q[24:20]);
  assign doNOP     = branch_taken || hazard;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

  // Redirect targets are word aligned; the low bits are dropped
  assign unused_target_bits = ^branch_target[1:0];

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: fetch sequencing, load-use stall, redirect, wrap, reset.
module tb_if_id_stage;

  localparam logic [31:0] ADD_X3_X1_X2 = 32'h0020_81B3;
  localparam logic [31:0] LUI_X5_F1    = 32'h0000_82B7;
  localparam logic [31:0] LUI_X5_F0    = 32'h0000_12B7;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        ex_memRead;
  logic [4:0]  ex_regToWrite;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        id_valid;
  logic [4:0]  Rs1;
  logic [4:0]  Rs2;
  logic        doNOP;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  logic        mem_fixed;
  logic [31:0] fixed_inst;
  int          errors;
  int          checks;

  // Sequential memory: addi x0,x0,(addr>>2) at every word; can be overridden with one word
  function automatic logic [31:0] seq_inst(input logic [31:0] addr);
    return {addr[13:2], 20'h00013};
  endfunction

  assign imem_rdata = mem_fixed ? fixed_inst : seq_inst(imem_addr);

  if_id_stage dut (
    .clk          (clk),
    .rst          (rst),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .ex_memRead   (ex_memRead),
    .ex_regToWrite(ex_regToWrite),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .id_inst      (id_inst),
    .id_pc        (id_pc),
    .id_valid     (id_valid),
    .Rs1          (Rs1),
    .Rs2          (Rs2),
    .doNOP        (doNOP),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want %h", imem_addr, 32'h0); end
    checks++; if (id_inst !== 32'h13) begin errors++; $display("FAIL reset_inst: got %h want %h", id_inst, 32'h13); end
    checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL reset_idpc: got %h want %h", id_pc, 32'h0); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", id_valid); end
    checks++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnts: got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
    checks++; if (doNOP !== 1'b0) begin errors++; $display("FAIL reset_donop: got %b want 0", doNOP); end
    checks++; if (Rs1 !== 5'd0 || Rs2 !== 5'd0) begin errors++; $display("FAIL reset_rs: got %0d/%0d want 0/0", Rs1, Rs2); end
    rst = 1'b0;
  endtask

  task automatic test_seq_fetch();
    for (int i = 0; i < 4; i++) begin
      checks++; if (imem_addr !== 32'(4 * i)) begin errors++; $display("FAIL seq_addr%0d: got %h want %h", i, imem_addr, 32'(4 * i)); end
      if (i == 0) begin
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL seq_valid0: got %b want 0", id_valid); end
      end else begin
        checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL seq_valid%0d: got %b want 1", i, id_valid); end
        checks++; if (id_pc !== 32'(4 * (i - 1))) begin errors++; $display("FAIL seq_idpc%0d: got %h want %h", i, id_pc, 32'(4 * (i - 1))); end
        checks++; if (id_inst !== seq_inst(32'(4 * (i - 1)))) begin errors++; $display("FAIL seq_inst%0d: got %h want %h", i, id_inst, seq_inst(32'(4 * (i - 1)))); end
      end
      step();
    end
  endtask

  task automatic test_load_use();
    mem_fixed = 1'b1; fixed_inst = ADD_X3_X1_X2;
    step();
    mem_fixed = 1'b0;
    checks++; if (id_inst !== ADD_X3_X1_X2 || imem_addr !== 32'd20) begin errors++; $display("FAIL lu_setup: got %h @%h want %h @%h", id_inst, imem_addr, ADD_X3_X1_X2, 32'd20); end
    ex_memRead = 1'b1; ex_regToWrite = 5'd1;
    #1;
    checks++; if (doNOP !== 1'b1) begin errors++; $display("FAIL lu_donop: got %b want 1", doNOP); end
    step();
    checks++; if (imem_addr !== 32'd20) begin errors++; $display("FAIL lu_pc_hold: got %h want %h", imem_addr, 32'd20); end
    checks++; if (id_inst !== ADD_X3_X1_X2 || id_pc !== 32'd16) begin errors++; $display("FAIL lu_id_hold: got %h @%h want %h @%h", id_inst, id_pc, ADD_X3_X1_X2, 32'd16); end
    checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_stallcnt: got %0d want 1", stall_cnt); end
    ex_memRead = 1'b0; ex_regToWrite = 5'd0;
    #1;
    checks++; if (doNOP !== 1'b0) begin errors++; $display("FAIL lu_clear: got %b want 0", doNOP); end
    step();
    checks++; if (imem_addr !== 32'd24 || id_pc !== 32'd20 || id_inst !== seq_inst(32'd20)) begin errors++; $display("FAIL lu_resume: got %h/%h/%h want %h/%h/%h", imem_addr, id_pc, id_inst, 32'd24, 32'd20, seq_inst(32'd20)); end
  endtask

  task automatic test_no_hazard();
    mem_fixed = 1'b1; fixed_inst = ADD_X3_X1_X2;
    step();
    ex_memRead = 1'b1; ex_regToWrite = 5'd0;
    fixed_inst = LUI_X5_F1;
    #1;
    checks++; if (doNOP !== 1'b0) begin errors++; $display("FAIL nh_x0: got %b want 0", doNOP); end
    step();
    checks++; if (imem_addr !== 32'd32 || stall_cnt !== 16'd1) begin errors++; $display("FAIL nh_x0_flow: got %h cnt %0d want %h cnt 1", imem_addr, stall_cnt, 32'd32); end
    checks++; if (id_inst !== LUI_X5_F1 || Rs1 !== 5'd1 || Rs2 !== 5'd0) begin errors++; $display("FAIL nh_lui_slice: got %h rs %0d/%0d want %h rs 1/0", id_inst, Rs1, Rs2, LUI_X5_F1); end
    ex_regToWrite = 5'd1;
    #1;
    checks++; if (doNOP !== 1'b0) begin errors++; $display("FAIL nh_lui_rs1: got %b want 0", doNOP); end
    fixed_inst = LUI_X5_F0;
    step();
    checks++; if (imem_addr !== 32'd36 || stall_cnt !== 16'd1) begin errors++; $display("FAIL nh_lui_flow: got %h cnt %0d want %h cnt 1", imem_addr, stall_cnt, 32'd36); end
    ex_regToWrite = 5'd0;
    #1;
    checks++; if (doNOP !== 1'b0 || Rs1 !== 5'd0) begin errors++; $display("FAIL nh_lui_x0: got %b rs1 %0d want 0 rs1 0", doNOP, Rs1); end
    ex_memRead = 1'b0;
    mem_fixed = 1'b0;
  endtask

  task automatic test_redirect();
    mem_fixed = 1'b1; fixed_inst = ADD_X3_X1_X2;
    step();
    mem_fixed = 1'b0;
    ex_memRead = 1'b1; ex_regToWrite = 5'd2;
    branch_taken = 1'b1; branch_target = 32'h0000_0103;
    #1;
    checks++; if (doNOP !== 1'b1) begin errors++; $display("FAIL rd_donop: got %b want 1", doNOP); end
    step();
    branch_taken = 1'b0; ex_memRead = 1'b0; ex_regToWrite = 5'd0;
    checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL rd_addr: got %h want %h", imem_addr, 32'h100); end
    checks++; if (id_valid !== 1'b0 || id_inst !== 32'h13 || id_pc !== 32'h0) begin errors++; $display("FAIL rd_bubble: got %b/%h/%h want 0/%h/%h", id_valid, id_inst, id_pc, 32'h13, 32'h0); end
    checks++; if (flush_cnt !== 16'd1 || stall_cnt !== 16'd1) begin errors++; $display("FAIL rd_cnts: got %0d/%0d want 1/1", flush_cnt, stall_cnt); end
    #1;
    checks++; if (doNOP !== 1'b0) begin errors++; $display("FAIL rd_donop_after: got %b want 0", doNOP); end
  endtask

  task automatic test_pc_wrap();
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFF;
    step();
    branch_taken = 1'b0;
    checks++; if (imem_addr !== 32'hFFFF_FFFC || flush_cnt !== 16'd2) begin errors++; $display("FAIL wrap_setup: got %h cnt %0d want %h cnt 2", imem_addr, flush_cnt, 32'hFFFF_FFFC); end
    step();
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr: got %h want %h", imem_addr, 32'h0); end
    checks++; if (id_pc !== 32'hFFFF_FFFC || id_valid !== 1'b1 || id_inst !== 32'hFFF0_0013) begin errors++; $display("FAIL wrap_id: got %h/%b/%h want %h/1/%h", id_pc, id_valid, id_inst, 32'hFFFF_FFFC, 32'hFFF0_0013); end
  endtask

  task automatic test_reset_mid_stall();
    mem_fixed = 1'b1; fixed_inst = ADD_X3_X1_X2;
    step();
    mem_fixed = 1'b0;
    ex_memRead = 1'b1; ex_regToWrite = 5'd1;
    #1;
    checks++; if (doNOP !== 1'b1) begin errors++; $display("FAIL rs_pre_donop: got %b want 1", doNOP); end
    rst = 1'b1;
    step();
    checks++; if (imem_addr !== 32'h0 || id_valid !== 1'b0) begin errors++; $display("FAIL rs_state: got %h/%b want %h/0", imem_addr, id_valid, 32'h0); end
    checks++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin errors++; $display("FAIL rs_cnts: got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
    checks++; if (doNOP !== 1'b0) begin errors++; $display("FAIL rs_donop: got %b want 0", doNOP); end
    rst = 1'b0; ex_memRead = 1'b0; ex_regToWrite = 5'd0;
    step();
    checks++; if (imem_addr !== 32'd4 || id_pc !== 32'd0 || id_valid !== 1'b1) begin errors++; $display("FAIL rs_resume: got %h/%h/%b want %h/%h/1", imem_addr, id_pc, id_valid, 32'd4, 32'd0); end
  endtask

  initial begin
    errors = 0; checks = 0;
    rst = 1'b0; ex_memRead = 1'b0; ex_regToWrite = 5'd0;
    branch_taken = 1'b0; branch_target = 32'h0;
    mem_fixed = 1'b0; fixed_inst = 32'h0;
    test_reset();
    test_seq_fetch();
    test_load_use();
    test_no_hazard();
    test_redirect();
    test_pc_wrap();
    test_reset_mid_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
